// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: latches two operands, adds them LSB-first through a
// carry-registered full-adder slice built from two half-adder stages, then pulses done.

module serial_add_seq_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_sum, bit_carry;

  // Full-adder slice: first stage adds the operand bits, second folds in the carry.
  serial_add_seq_ha u_ha0 (
    .x (a_sh_q[0]),
    .y (b_sh_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  serial_add_seq_ha u_ha1 (
    .x (ha0_s),
    .y (c_q),
    .s (ha1_s),
    .c (ha1_c)
  );

  assign bit_sum   = ha1_s;
  assign bit_carry = ha0_c | ha1_c;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            c_d     = 1'b0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          c_d    = bit_carry;
          sum_d  = {bit_sum, sum_q[WIDTH-1:1]};
          a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cout_d  = bit_carry;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule
